// File: rtl/uart_tx_cfg_if.sv
// Word handshake between the upstream producer (register file / TX FIFO)
// and the configurable UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    logic                tx_valid;
    logic                tx_ready;
    logic [DBIT_MAX-1:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-word holding register.
// Data bits, parity and stop bits are latched per frame at frame load.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (tx=0) for one bit period
// DATA   | data bits LSB first, n counts 0..dbits-1
// PARITY | even/odd parity over the transmitted data bits
// STOP   | tx=1 for one or two bit periods, reload or return to IDLE
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OVS      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_tick,
    input  logic [3:0]   cfg_dbits,
    input  logic [1:0]   cfg_parity,
    input  logic         cfg_stop2,
    uart_tx_cfg_if.slave tx_if,
    output logic         tx_busy,
    output logic         tx_done_tick,
    output logic         tx
);

    localparam int            SW     = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [3:0]    DB_MAX = 4'(DBIT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       s_cnt_q, s_cnt_d;
    logic [3:0]          n_q, n_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic [DBIT_MAX-1:0] hold_data_q, hold_data_d;
    logic                hold_full_q, hold_full_d;
    logic                par_q, par_d;
    logic [3:0]          f_dbits_q, f_dbits_d;
    logic [1:0]          f_parity_q, f_parity_d;
    logic                f_stop2_q, f_stop2_d;
    logic                tx_q, tx_d;

    logic       bit_end;
    logic       last_stop;
    logic       frame_end;
    logic       load;
    logic       accept;
    logic       par_en;
    logic       par_next;
    logic [3:0] eff_dbits;

    // Out-of-range widths are clamped rather than rejected.
    always_comb begin
        eff_dbits = cfg_dbits;
        if (cfg_dbits < 4'd5) begin
            eff_dbits = 4'd5;
        end else if (cfg_dbits > DB_MAX) begin
            eff_dbits = DB_MAX;
        end
    end

    assign bit_end   = s_tick && (s_cnt_q == S_LAST);
    assign last_stop = !f_stop2_q || stop_cnt_q;
    assign frame_end = (state_q == STOP) && bit_end && last_stop;
    assign load      = hold_full_q && ((state_q == IDLE) || frame_end);
    // A word offered on a load edge is taken even though tx_ready reads 0.
    assign accept    = tx_if.tx_valid && (!hold_full_q || load);
    assign par_en    = f_parity_q[0] ^ f_parity_q[1];
    assign par_next  = par_q ^ shift_q[0];

    assign tx_if.tx_ready = !hold_full_q;
    assign tx_busy        = (state_q != IDLE);
    assign tx             = tx_q;

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_d          = n_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        hold_data_d  = hold_data_q;
        hold_full_d  = hold_full_q;
        par_d        = par_q;
        f_dbits_d    = f_dbits_q;
        f_parity_d   = f_parity_q;
        f_stop2_d    = f_stop2_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;

        if ((state_q != IDLE) && s_tick) begin
            s_cnt_d = bit_end ? '0 : s_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    n_d     = 4'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_next;
                    if (n_q == f_dbits_q - 4'd1) begin
                        if (par_en) begin
                            state_d = PARITY;
                            tx_d    = f_parity_q[1] ? ~par_next : par_next;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        n_d  = n_q + 4'd1;
                        tx_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame load overrides the STOP exit so back-to-back frames have no gap.
        if (load) begin
            state_d     = START;
            s_cnt_d     = '0;
            n_d         = 4'd0;
            stop_cnt_d  = 1'b0;
            par_d       = 1'b0;
            shift_d     = hold_data_q;
            f_dbits_d   = eff_dbits;
            f_parity_d  = cfg_parity;
            f_stop2_d   = cfg_stop2;
            tx_d        = 1'b0;
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_data_d = tx_if.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_q         <= 4'd0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            f_dbits_q   <= 4'd0;
            f_parity_q  <= 2'b00;
            f_stop2_q   <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_q         <= n_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            f_dbits_q   <= f_dbits_d;
            f_parity_q  <= f_parity_d;
            f_stop2_q   <= f_stop2_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a line decoder captures frames, which are checked
// against hand-derived vectors and a per-frame model of the UART format.
module tb_uart_tx_cfg;

    localparam int DBIT_MAX = 8;
    localparam int OVS      = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tick;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    uart_tx_cfg_if #(.DBIT_MAX(DBIT_MAX)) bus ();

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .cfg_dbits    (cfg_dbits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .tx_if        (bus),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic        glitch;
        int          gap;
        logic [6:0]  cfg;
    } frame_t;

    typedef struct {
        logic [7:0]  word;
        logic [3:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] exp_bits;
        int          exp_len;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         spur_done = 0;
    bit         tick_en   = 1'b0;
    bit         tick_rand = 1'b0;
    int         tick_div  = 1;
    logic [6:0] cfg_snap;
    frame_t     cap_q[$];
    logic [7:0] word_q[$];
    vec_t       vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line levels per bit period, straight from the frame format.
    function automatic void model(input logic [7:0] w, input logic [6:0] c,
                                  output logic [15:0] b, output int len);
        int   d;
        logic x;
        d = int'(c[6:3]);
        if (d < 5) d = 5;
        if (d > DBIT_MAX) d = DBIT_MAX;
        b = '0; len = 1; x = 1'b0;
        for (int i = 0; i < d; i++) begin
            b[len] = w[i]; x = x ^ w[i]; len++;
        end
        if (c[2:1] == 2'b01) begin b[len] = x;  len++; end
        if (c[2:1] == 2'b10) begin b[len] = ~x; len++; end
        b[len] = 1'b1; len++;
        if (c[0]) begin b[len] = 1'b1; len++; end
    endfunction

    always @(posedge clk) cfg_snap <= {cfg_dbits, cfg_parity, cfg_stop2};

    initial begin
        int ph;
        ph = 0; s_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!tick_en) begin
                s_tick = 1'b0; ph = 0;
            end else if (tick_rand) begin
                s_tick = ($urandom_range(0, 2) == 0);
            end else begin
                ph = (ph + 1) % tick_div;
                s_tick = (ph == 0);
            end
        end
    end

    // Line decoder: samples tx on every tick, one level per OVS ticks.
    initial begin
        bit     in_frame;
        int     tick, gap;
        logic   lvl;
        frame_t f;
        in_frame = 0; tick = 0; gap = 0; lvl = 1'b1;
        f = '{bits: '0, len: 0, glitch: 1'b0, gap: 0, cfg: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0; gap = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1; tick = 0;
                    f = '{bits: '0, len: 0, glitch: 1'b0, gap: gap, cfg: cfg_snap};
                end
                if (!in_frame) gap++;
                if (tx_done_tick && !(in_frame && s_tick)) spur_done++;
                if (in_frame && s_tick) begin
                    if (tick == 0) lvl = tx;
                    else if (tx !== lvl) f.glitch = 1'b1;
                    tick++;
                    if (tick == OVS) begin
                        if (f.len < 16) f.bits[f.len] = lvl;
                        f.len++; tick = 0;
                    end
                    if (tx_done_tick || f.len > 16) begin
                        if (tick != 0 || f.len > 16) f.glitch = 1'b1;
                        cap_q.push_back(f); in_frame = 0; gap = 0;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] w);
        bit acc;
        int g;
        bus.tx_valid = 1'b1; bus.tx_data = w; acc = 0; g = 0;
        while (!acc && g < 5000) begin
            @(negedge clk);
            acc = tx_ready_now() || tx_done_tick || !tx_busy;
            @(posedge clk); #1;
            g++;
        end
        bus.tx_valid = 1'b0;
        if (acc) word_q.push_back(w);
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic bit tx_ready_now();
        return bus.tx_ready === 1'b1;
    endfunction

    task automatic wait_frames(input int n, input int budget);
        int g;
        g = 0;
        while (cap_q.size() < n && g < budget) begin
            @(posedge clk); #1; g++;
        end
        if (cap_q.size() < n) check("frame_timeout", 32'(cap_q.size()), 32'(n));
    endtask

    task automatic check_model(input string name, output int gap);
        frame_t     f;
        logic [7:0] w;
        logic [15:0] b;
        int         len;
        gap = -1;
        if (cap_q.size() == 0 || word_q.size() == 0) begin
            check({name, "_missing"}, 32'(cap_q.size()), 32'(word_q.size() + 1));
        end else begin
            f = cap_q.pop_front(); w = word_q.pop_front(); gap = f.gap;
            model(w, f.cfg, b, len);
            check(name, {8'd0, f.glitch, 7'(f.len), f.bits}, {8'd0, 1'b0, 7'(len), b});
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((tx_busy || !tx_ready_now()) && g < 5000) begin
            @(posedge clk); #1; g++;
        end
    endtask

    task automatic set_cfg(input logic [3:0] d, input logic [1:0] p, input logic s2);
        cfg_dbits = d; cfg_parity = p; cfg_stop2 = s2;
    endtask

    initial begin
        int     cnt, gap, n, chg, spur0;
        logic   t0;
        frame_t f;
        logic [7:0] w;

        vt[0] = '{8'h55, 4'd8,  2'b00, 1'b0, 16'h02AA, 10};
        vt[1] = '{8'h41, 4'd7,  2'b01, 1'b1, 16'h0682, 11};
        vt[2] = '{8'h41, 4'd7,  2'b10, 1'b0, 16'h0382, 10};
        vt[3] = '{8'hF3, 4'd2,  2'b00, 1'b0, 16'h0066, 7};
        vt[4] = '{8'h96, 4'd12, 2'b01, 1'b0, 16'h052C, 11};
        vt[5] = '{8'h2A, 4'd6,  2'b10, 1'b1, 16'h0354, 10};
        vt[6] = '{8'h1F, 4'd5,  2'b11, 1'b0, 16'h007E, 7};

        rst_n = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        set_cfg(4'd8, 2'b00, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done_tick), 32'd0);
        rst_n = 1'b1; tick_en = 1'b1; tick_div = 1;
        repeat (2) @(posedge clk); #1;

        // 8N1 0x55, one tick per clk: load latency and done timing.
        send_word(8'h55);
        check("lat_held_ready", 32'(bus.tx_ready), 32'd0);
        check("lat_held_tx", 32'(tx), 32'd1);
        @(posedge clk); #1;
        check("lat_load_tx", 32'(tx), 32'd0);
        check("lat_load_ready", 32'(bus.tx_ready), 32'd1);
        check("lat_load_busy", 32'(tx_busy), 32'd1);
        cnt = 0;
        do begin
            @(negedge clk); cnt++;
        end while (!tx_done_tick && cnt < 400);
        check("done_at_160", 32'(cnt), 32'd160);
        @(posedge clk); #1;
        check("busy_fall", 32'(tx_busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("done_one_clk", 32'(tx_done_tick), 32'd0);
        @(posedge clk); #1;
        wait_frames(1, 500);
        check_model("frame_8n1", gap);

        // Hand-derived frames; every config input is scrambled mid-frame.
        for (int i = 0; i < 7; i++) begin
            tick_div = (i < 3) ? 1 : 2;
            wait_idle();
            set_cfg(vt[i].dbits, vt[i].par, vt[i].stop2);
            send_word(vt[i].word);
            repeat (40) @(posedge clk); #1;
            set_cfg((vt[i].dbits > 4'd6) ? 4'd5 : 4'd8, vt[i].par ^ 2'b11, ~vt[i].stop2);
            wait_frames(1, 1000);
            if (cap_q.size() > 0 && word_q.size() > 0) begin
                f = cap_q.pop_front(); w = word_q.pop_front();
                check($sformatf("vec%0d", i), {8'd0, f.glitch, 7'(f.len), f.bits},
                      {8'd0, 1'b0, 7'(vt[i].exp_len), vt[i].exp_bits});
            end
        end

        // Back-to-back with tx_valid held high, one tick every third clk.
        wait_idle();
        tick_div = 3;
        set_cfg(4'd8, 2'b00, 1'b0);
        send_word(8'hA5);
        send_word(8'h3C);
        check("b2b_ready_low", 32'(bus.tx_ready), 32'd0);
        send_word(8'hFF);
        check("b2b_ready_low2", 32'(bus.tx_ready), 32'd0);
        wait_frames(3, 3000);
        for (int k = 0; k < 3; k++) begin
            check_model($sformatf("b2b_frame%0d", k), gap);
            if (k > 0) check($sformatf("b2b_gap%0d", k), 32'(gap), 32'd0);
        end

        // Reset in the middle of DATA with a word held.
        wait_idle();
        tick_div = 1;
        send_word(8'hC3);
        send_word(8'h3C);
        repeat (40) @(posedge clk); #1;
        spur0 = spur_done;
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_ready", 32'(bus.tx_ready), 32'd1);
        check("arst_busy", 32'(tx_busy), 32'd0);
        check("arst_done", 32'(tx_done_tick), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk); #1;
        check("arst_no_frame", 32'(cap_q.size()), 32'd0);
        check("arst_no_done", 32'(spur_done), 32'(spur0));
        check("arst_idle", 32'(tx_busy), 32'd0);
        word_q.delete(); cap_q.delete();
        set_cfg(4'd8, 2'b10, 1'b0);
        send_word(8'h5A);
        wait_frames(1, 1000);
        check_model("post_rst_frame", gap);

        // s_tick stalled for 100 clks mid-frame.
        wait_idle();
        set_cfg(4'd7, 2'b01, 1'b0);
        send_word(8'h69);
        repeat (50) @(posedge clk); #1;
        tick_en = 1'b0;
        @(posedge clk); #2;
        t0 = tx; chg = 0;
        repeat (100) begin
            @(posedge clk); #2;
            if (tx !== t0 || tx_busy !== 1'b1) chg++;
        end
        check("freeze_hold", 32'(chg), 32'd0);
        tick_en = 1'b1;
        @(posedge clk); #1;
        wait_frames(1, 1000);
        check_model("freeze_frame", gap);

        // Random words, configs, gaps and tick pattern against the model.
        wait_idle();
        tick_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            set_cfg(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            send_word(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 300)) @(posedge clk);
                #1;
            end
        end
        n = word_q.size();
        wait_frames(n, 30000);
        for (int r = 0; r < n; r++) check_model($sformatf("rand%0d", r), gap);
        check("spurious_done", 32'(spur_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
